// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath: element/dimension widths, op codes
// and the sequencer state encoding. Also imported by the menu FSM.
package matrix_pkg;

    localparam int DATA_W  = 16;
    localparam int DIM_W   = 3;
    localparam int MAX_DIM = 5;

    typedef enum logic [1:0] {
        OP_ADD       = 2'd0,
        OP_SCALAR    = 2'd1,
        OP_TRANSPOSE = 2'd2,
        OP_MUL       = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_COMPUTE,
        ST_ALLOC,
        ST_WRITE,
        ST_DONE
    } seq_state_e;

    function automatic logic id_ok(input logic [1:0] id);
        return (id == 2'd1) || (id == 2'd2);
    endfunction

endpackage

// File: rtl/matrix_res_buf.sv
// Result staging buffer: one synchronous write port, one combinational read port,
// addressed linearly as row*MAX_DIM+col.
module matrix_res_buf #(
    parameter int DATA_W = matrix_pkg::DATA_W,
    parameter int DEPTH  = matrix_pkg::MAX_DIM * matrix_pkg::MAX_DIM,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage is not reset; every entry read back is written earlier in the same op.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/matrix_op_sequencer.sv
// Matrix ALU sequencer: reads operands from matrix_mem, buffers the whole result,
// then allocates one result slot and writes the result back.
module matrix_op_sequencer #(
    parameter int DATA_W  = matrix_pkg::DATA_W,
    parameter int DIM_W   = matrix_pkg::DIM_W,
    parameter int MAX_DIM = matrix_pkg::MAX_DIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DIM_W-1:0]  a_m,
    input  logic [DIM_W-1:0]  a_n,
    input  logic [1:0]        a_id,
    input  logic [DIM_W-1:0]  b_m,
    input  logic [DIM_W-1:0]  b_n,
    input  logic [1:0]        b_id,
    input  logic [DATA_W-1:0] scalar,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DIM_W-1:0]  res_m,
    output logic [DIM_W-1:0]  res_n,
    output logic [DIM_W-1:0]  alu_a_m,
    output logic [DIM_W-1:0]  alu_a_n,
    output logic [DIM_W-1:0]  alu_a_row,
    output logic [DIM_W-1:0]  alu_a_col,
    output logic [1:0]        alu_a_id,
    input  logic [DATA_W-1:0] alu_a_data,
    output logic [DIM_W-1:0]  alu_b_m,
    output logic [DIM_W-1:0]  alu_b_n,
    output logic [DIM_W-1:0]  alu_b_row,
    output logic [DIM_W-1:0]  alu_b_col,
    output logic [1:0]        alu_b_id,
    input  logic [DATA_W-1:0] alu_b_data,
    output logic [DIM_W-1:0]  alu_res_m,
    output logic [DIM_W-1:0]  alu_res_n,
    output logic              alu_res_dim_we,
    output logic [DIM_W-1:0]  alu_res_row,
    output logic [DIM_W-1:0]  alu_res_col,
    output logic [DATA_W-1:0] alu_res_data,
    output logic              alu_res_we
);
    import matrix_pkg::*;

    localparam int BUF_DEPTH = MAX_DIM * MAX_DIM;
    localparam int BUF_AW    = $clog2(BUF_DEPTH);

    function automatic logic [BUF_AW-1:0] lin(input logic [DIM_W-1:0] row, input logic [DIM_W-1:0] col);
        return BUF_AW'(int'(row) * MAX_DIM + int'(col));
    endfunction

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (int'(d) <= MAX_DIM);
    endfunction

    seq_state_e        state;
    op_e               op_q;
    logic [DATA_W-1:0] scalar_q, acc, prod, elem_val, buf_rd_data;
    logic [DIM_W-1:0]  r, c, k, nxt_r, nxt_c, nxt_k;
    logic [DIM_W-1:0]  a_row_nx, a_col_nx, b_row_nx, b_col_nx;
    logic              is_mul, k_last, elem_step, c_last, r_last, last_elem;
    logic              a_ok, b_ok, bad;
    logic              buf_we;
    logic [BUF_AW-1:0] buf_rd_addr;

    assign is_mul = (op_q == OP_MUL);

    // Result walk: k innermost (MUL only), then column, then row; wraps at res dims.
    // NOTE: always_comb uses blocking '=' with a default for every output first, so no latch is inferred.
    always_comb begin
        k_last    = !is_mul || (k == alu_a_n - 1'b1);
        elem_step = (state == ST_COMPUTE) ? k_last : 1'b1;
        c_last    = (c == res_n - 1'b1);
        r_last    = (r == res_m - 1'b1);
        last_elem = elem_step && c_last && r_last;
        nxt_k     = k;
        nxt_c     = c;
        nxt_r     = r;
        if (!elem_step) begin
            nxt_k = k + 1'b1;
        end else begin
            nxt_k = '0;
            if (!c_last) begin
                nxt_c = c + 1'b1;
            end else begin
                nxt_c = '0;
                nxt_r = r_last ? '0 : r + 1'b1;
            end
        end
    end

    always_comb begin
        a_row_nx = nxt_r;
        a_col_nx = nxt_c;
        b_row_nx = nxt_r;
        b_col_nx = nxt_c;
        case (op_q)
            OP_TRANSPOSE: begin
                a_row_nx = nxt_c;
                a_col_nx = nxt_r;
                b_row_nx = '0;
                b_col_nx = '0;
            end
            OP_SCALAR: begin
                b_row_nx = '0;
                b_col_nx = '0;
            end
            OP_MUL: begin
                a_col_nx = nxt_k;
                b_row_nx = nxt_k;
            end
            default: ;
        endcase
    end

    always_comb begin
        prod = is_mul ? alu_a_data * alu_b_data : alu_a_data * scalar_q;
        case (op_q)
            OP_ADD:       elem_val = alu_a_data + alu_b_data;
            OP_SCALAR:    elem_val = prod;
            OP_TRANSPOSE: elem_val = alu_a_data;
            default:      elem_val = acc + prod;
        endcase
    end

    always_comb begin
        a_ok = dim_ok(alu_a_m) && dim_ok(alu_a_n) && id_ok(alu_a_id);
        b_ok = dim_ok(alu_b_m) && dim_ok(alu_b_n) && id_ok(alu_b_id);
        case (op_q)
            OP_ADD:  bad = !a_ok || !b_ok || (alu_a_m != alu_b_m) || (alu_a_n != alu_b_n);
            OP_MUL:  bad = !a_ok || !b_ok || (alu_a_n != alu_b_m);
            default: bad = !a_ok;
        endcase
    end

    assign buf_we      = (state == ST_COMPUTE) && k_last;
    assign buf_rd_addr = (state == ST_WRITE) ? lin(nxt_r, nxt_c) : '0;

    matrix_res_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH),
        .AW     (BUF_AW)
    ) u_res_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (lin(r, c)),
        .wr_data (elem_val),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            op_q           <= OP_ADD;
            scalar_q       <= '0;
            acc            <= '0;
            {r, c, k}      <= '0;
            {busy, done, err} <= '0;
            {res_m, res_n} <= '0;
            {alu_a_m, alu_a_n, alu_a_row, alu_a_col, alu_a_id} <= '0;
            {alu_b_m, alu_b_n, alu_b_row, alu_b_col, alu_b_id} <= '0;
            {alu_res_m, alu_res_n, alu_res_row, alu_res_col} <= '0;
            alu_res_dim_we <= 1'b0;
            alu_res_we     <= 1'b0;
            alu_res_data   <= '0;
        end else begin
            done           <= 1'b0;
            alu_res_dim_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op_e'(op);
                        scalar_q  <= scalar;
                        alu_a_m   <= a_m;
                        alu_a_n   <= a_n;
                        alu_a_id  <= a_id;
                        alu_b_m   <= b_m;
                        alu_b_n   <= b_n;
                        alu_b_id  <= b_id;
                        {alu_a_row, alu_a_col, alu_b_row, alu_b_col} <= '0;
                        {r, c, k} <= '0;
                        acc       <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    case (op_q)
                        OP_TRANSPOSE: begin res_m <= alu_a_n; res_n <= alu_a_m; end
                        OP_MUL:       begin res_m <= alu_a_m; res_n <= alu_b_n; end
                        default:      begin res_m <= alu_a_m; res_n <= alu_a_n; end
                    endcase
                    if (bad) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    {r, c, k} <= {nxt_r, nxt_c, nxt_k};
                    alu_a_row <= a_row_nx;
                    alu_a_col <= a_col_nx;
                    alu_b_row <= b_row_nx;
                    alu_b_col <= b_col_nx;
                    acc       <= k_last ? '0 : elem_val;
                    if (last_elem) begin
                        alu_res_m      <= res_m;
                        alu_res_n      <= res_n;
                        alu_res_dim_we <= 1'b1;
                        state          <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    alu_res_we   <= 1'b1;
                    alu_res_row  <= '0;
                    alu_res_col  <= '0;
                    alu_res_data <= buf_rd_data;
                    state        <= ST_WRITE;
                end
                ST_WRITE: begin
                    {r, c} <= {nxt_r, nxt_c};
                    if (last_elem) begin
                        alu_res_we <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_DONE;
                    end else begin
                        alu_res_row  <= nxt_r;
                        alu_res_col  <= nxt_c;
                        alu_res_data <= buf_rd_data;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
